uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an internal transmit FIFO. It supports configurable data width, optional parity and 1 or 2 stop bits. Sits between core-side producers (debug/telemetry writers) and the board TX pin. Producers push bytes without waiting per frame, and frames go out back-to-back with no idle gap while the FIFO holds data.

---
 rtl/uart_tx_fifo.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular transmit FIFO.
// Frames are start + DATA_BITS (LSB first) + optional parity + stop bit(s), sent back-to-back while data is queued.
module uart_tx_fifo #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int CLK_COUNT_BIT = CLK_FREQ / BAUD_RATE,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 16,
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 begin_flag,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 busy_flag,
  output logic                 full_flag,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 drop_flag
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLK_COUNT_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_COUNT_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;
  logic                 empty;

  logic [2:0]           state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;
  logic                 bit_end;

  // The registered full flag gates the push, so a push racing a pop on a full FIFO is dropped.
  assign push      = begin_flag && !full_flag;
  assign empty     = (fifo_count == '0);
  assign head      = mem[rd_ptr];
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign pop       = !empty && ((state == S_IDLE) ||
                                (state == S_STOP && bit_end && stop_cnt == STOP_LAST));
  assign busy_flag = !empty || (state != S_IDLE);

  // NOTE: storage has no reset; only pointers and count define validity, which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      full_flag  <= 1'b0;
      drop_flag  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10: begin
          fifo_count <= fifo_count + CNT_W'(1);
          full_flag  <= (fifo_count == DEPTH_C - CNT_W'(1));
        end
        2'b01: begin
          fifo_count <= fifo_count - CNT_W'(1);
          full_flag  <= 1'b0;
        end
        default: ;
      endcase
      drop_flag <= begin_flag && full_flag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
    end else begin
      if (state == S_IDLE || bit_end) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + BAUD_W'(1);

      if (pop) begin
        // Capture the word and its parity now so later FIFO writes cannot disturb the frame.
        shift_reg  <= head;
        parity_bit <= (PARITY == 1) ? ~^head : ^head;
        bit_cnt    <= '0;
        stop_cnt   <= 1'b0;
        state      <= S_START;
        tx         <= 1'b0;
      end else begin
        case (state)
          S_IDLE: tx <= 1'b1;
          S_START: if (bit_end) begin
            state     <= S_DATA;
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
          S_DATA: if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
              if (PARITY != 0) begin
                state <= S_PARITY;
                tx    <= parity_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + BIT_W'(1);
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
          S_PARITY: if (bit_end) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
          S_STOP: if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (8N1 depth 4, 7O2, 8E1) at 4 clocks per bit.
// Line monitors decode every frame cycle by cycle and compare against a per-instance scoreboard.
module tb_uart_tx_fifo;

  localparam int CB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       bf0, bf1, bf2;
  logic [7:0] d0;
  logic [6:0] d1;
  logic [7:0] d2;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic       full0, full1, full2;
  logic       drop0, drop1, drop2;
  logic [2:0] cnt0;
  logic [4:0] cnt1, cnt2;

  uart_tx_fifo #(.CLK_FREQ(400), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .begin_flag(bf0), .data(d0), .tx(tx0),
    .busy_flag(busy0), .full_flag(full0), .fifo_count(cnt0), .drop_flag(drop0));

  uart_tx_fifo #(.CLK_FREQ(400), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .begin_flag(bf1), .data(d1), .tx(tx1),
    .busy_flag(busy1), .full_flag(full1), .fifo_count(cnt1), .drop_flag(drop1));

  uart_tx_fifo #(.CLK_FREQ(400), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .begin_flag(bf2), .data(d2), .tx(tx2),
    .busy_flag(busy2), .full_flag(full2), .fifo_count(cnt2), .drop_flag(drop2));

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int frames [3] = '{0, 0, 0};
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  int st0[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int nb_of(input int sel);
    return (sel == 1) ? 7 : 8;
  endfunction

  function automatic int par_of(input int sel);
    return sel;
  endfunction

  function automatic int sb_of(input int sel);
    return (sel == 1) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int sel);
    return (1 + nb_of(sel) + ((par_of(sel) != 0) ? 1 : 0) + sb_of(sel)) * CB;
  endfunction

  function automatic logic tx_of(input int sel);
    case (sel)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  // Expected line bits: start, data LSB first, parity, stops; unused high bits stay 1.
  function automatic logic [15:0] make_frame(input int sel, input logic [8:0] d);
    logic [15:0] f;
    int k;
    int ones;
    f = '1;
    f[0] = 1'b0;
    k = 1;
    ones = 0;
    for (int i = 0; i < nb_of(sel); i++) begin
      f[k] = d[i];
      if (d[i]) ones++;
      k++;
    end
    if (par_of(sel) == 1) f[k] = (ones % 2 == 0);
    if (par_of(sel) == 2) f[k] = (ones % 2 == 1);
    return f;
  endfunction

  function automatic void sb_push(input int sel, input logic [8:0] d);
    case (sel)
      0:       q0.push_back(make_frame(sel, d));
      1:       q1.push_back(make_frame(sel, d));
      default: q2.push_back(make_frame(sel, d));
    endcase
  endfunction

  function automatic int sb_size(input int sel);
    case (sel)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [15:0] sb_pop(input int sel);
    case (sel)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic run_monitor(input int sel);
    logic [15:0] obs;
    logic [15:0] exp;
    bit glitch;
    bit aborted;
    int len;
    int start;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_of(sel) === 1'b0) begin
        start   = cyc;
        len     = frame_len(sel);
        obs     = '1;
        glitch  = 1'b0;
        aborted = 1'b0;
        for (int c = 0; c < len; c++) begin
          if (c > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (c % CB == 0) obs[c / CB] = tx_of(sel);
          else if (tx_of(sel) !== obs[c / CB]) glitch = 1'b1;
        end
        if (!aborted) begin
          check($sformatf("mon%0d_sb_entry", sel), sb_size(sel) != 0, 1);
          if (sb_size(sel) != 0) begin
            exp = sb_pop(sel);
            check($sformatf("mon%0d_frame", sel), obs, exp);
          end
          check($sformatf("mon%0d_bit_stable", sel), glitch, 0);
          if (sel == 0) st0.push_back(start);
          frames[sel]++;
        end
      end
    end
  endtask

  initial run_monitor(0);
  initial run_monitor(1);
  initial run_monitor(2);

  task automatic wait_frames(input int sel, input int target, input int budget);
    int n = 0;
    while (frames[sel] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("frames_done%0d", sel), frames[sel], target);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w [6];
    int base;
    int lows;

    bf0 = 1'b0; bf1 = 1'b0; bf2 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx0", tx0, 1);
    check("rst_busy0", busy0, 0);
    check("rst_full0", full0, 0);
    check("rst_cnt0", cnt0, 0);
    check("rst_drop0", drop0, 0);
    check("rst_tx1", tx1, 1);
    check("rst_tx2", tx2, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1, single word 0x55: 40-cycle frame, busy drops one cycle after the stop bit.
    bf0 = 1'b1; d0 = 8'h55; sb_push(0, 9'h055);
    @(negedge clk);
    bf0 = 1'b0;
    check("t1_cnt_after_push", cnt0, 1);
    check("t1_busy_after_push", busy0, 1);
    check("t1_tx_idle_before_pop", tx0, 1);
    @(negedge clk);
    check("t1_tx_start", tx0, 0);
    check("t1_cnt_after_pop", cnt0, 0);
    repeat (39) @(negedge clk);
    check("t1_busy_last_stop", busy0, 1);
    check("t1_tx_last_stop", tx0, 1);
    @(negedge clk);
    check("t1_busy_end", busy0, 0);
    wait_frames(0, 1, 50);

    // 7O2, word 0x03: parity 1, two stops, 44-cycle frame.
    bf1 = 1'b1; d1 = 7'h03; sb_push(1, 9'h003);
    @(negedge clk);
    bf1 = 1'b0;
    @(negedge clk);
    check("t2_tx_start", tx1, 0);
    repeat (43) @(negedge clk);
    check("t2_busy_last_stop", busy1, 1);
    @(negedge clk);
    check("t2_busy_end", busy1, 0);
    wait_frames(1, 1, 50);

    // 8E1: 0xFF carries parity 0, 0x01 carries parity 1.
    bf2 = 1'b1; d2 = 8'hFF; sb_push(2, 9'h0FF);
    @(negedge clk);
    d2 = 8'h01; sb_push(2, 9'h001);
    @(negedge clk);
    bf2 = 1'b0;
    wait_frames(2, 2, 200);

    // Depth-4 FIFO, six consecutive pushes: five accepted, sixth dropped, no idle gaps.
    base = frames[0];
    st0.delete();
    w = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        check("t4_full", full0, 1);
        check("t4_cnt_full", cnt0, 4);
        check("t4_drop_before", drop0, 0);
      end
      bf0 = 1'b1; d0 = w[i];
      if (i < 5) sb_push(0, {1'b0, w[i]});
      @(negedge clk);
    end
    bf0 = 1'b0;
    check("t4_drop_pulse", drop0, 1);
    check("t4_cnt_after_drop", cnt0, 4);
    @(negedge clk);
    check("t4_drop_one_cycle", drop0, 0);
    wait_frames(0, base + 5, 400);
    check("t4_frame_starts", st0.size(), 5);
    for (int i = 1; i < st0.size(); i++)
      check($sformatf("t4_gap%0d", i), st0[i] - st0[i-1], 40);
    repeat (2) @(negedge clk);
    check("t4_busy_end", busy0, 0);
    check("t4_cnt_end", cnt0, 0);
    check("t4_full_end", full0, 0);

    // Reset mid-DATA with three words queued: everything clears at once and stays idle.
    for (int i = 0; i < 4; i++) begin
      bf0 = 1'b1; d0 = w[i];
      @(negedge clk);
    end
    bf0 = 1'b0;
    check("t5_cnt_queued", cnt0, 3);
    repeat (4) @(negedge clk);
    check("t5_in_frame", busy0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_tx_reset", tx0, 1);
    check("t5_cnt_reset", cnt0, 0);
    check("t5_busy_reset", busy0, 0);
    check("t5_full_reset", full0, 0);
    q0.delete();
    base = frames[0];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx0 !== 1'b1) lows++;
    end
    check("t5_line_idle", lows, 0);
    check("t5_busy_idle", busy0, 0);
    check("t5_no_frames", frames[0], base);

    // Push on the same edge as the stop-bit pop with two queued: count holds and order is kept.
    w = '{8'hC3, 8'h3C, 8'hE7, 8'h7E, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) begin
      bf0 = 1'b1; d0 = w[i]; sb_push(0, {1'b0, w[i]});
      @(negedge clk);
    end
    bf0 = 1'b0;
    check("t6_cnt_two", cnt0, 2);
    repeat (38) @(negedge clk);
    check("t6_cnt_before", cnt0, 2);
    check("t6_tx_last_stop", tx0, 1);
    bf0 = 1'b1; d0 = w[3]; sb_push(0, {1'b0, w[3]});
    @(negedge clk);
    bf0 = 1'b0;
    check("t6_cnt_same_edge", cnt0, 2);
    check("t6_next_start", tx0, 0);
    wait_frames(0, base + 4, 300);

    repeat (4) @(negedge clk);
    check("sb0_drained", q0.size(), 0);
    check("sb1_drained", q1.size(), 0);
    check("sb2_drained", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
